// File: rtl/chunked_add_sub_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chunked_add_sub_sequencer_pkg
// Brief    : Shared constants and types for the chunked 64-bit add/sub unit.
// Revision : 1.0 - initial release
// ============================================================================
package chunked_add_sub_sequencer_pkg;

    localparam int WIDTH      = 64;
    localparam int CHUNK      = 20;
    localparam int NUM_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK;
    // Width of the final, narrower chunk (bits 63:60).
    localparam int LAST_BITS  = WIDTH - CHUNK * (NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] idx_t;

endpackage
`default_nettype wire

// File: rtl/carry_look_ahead_adder_20.sv
`default_nettype none
// ============================================================================
// Module   : carry_look_ahead_adder_20
// Brief    : 20-bit carry-lookahead adder built from five 4-bit CLA groups
//            with group generate/propagate chained between groups.
// Revision : 1.0 - initial release
// ============================================================================
module carry_look_ahead_adder_20 (
    input  logic [19:0] i_a,
    input  logic [19:0] i_b,
    input  logic        i_c_in,
    output logic [19:0] o_sum,
    output logic        o_c_out
);

    localparam int GROUPS = 5;

    logic [19:0]       w_p;
    logic [19:0]       w_g;
    logic [20:0]       w_c;
    logic [GROUPS-1:0] w_gg;
    logic [GROUPS-1:0] w_gp;

    assign w_p    = i_a ^ i_b;
    assign w_g    = i_a & i_b;
    assign w_c[0] = i_c_in;

    generate
        for (genvar gi = 0; gi < GROUPS; gi++) begin : g_group
            localparam int c_base = gi * 4;
            // In-group carries from lookahead equations on the group carry-in.
            assign w_c[c_base+1] = w_g[c_base]
                                 | (w_p[c_base] & w_c[c_base]);
            assign w_c[c_base+2] = w_g[c_base+1]
                                 | (w_p[c_base+1] & w_g[c_base])
                                 | (w_p[c_base+1] & w_p[c_base] & w_c[c_base]);
            assign w_c[c_base+3] = w_g[c_base+2]
                                 | (w_p[c_base+2] & w_g[c_base+1])
                                 | (w_p[c_base+2] & w_p[c_base+1] & w_g[c_base])
                                 | (w_p[c_base+2] & w_p[c_base+1] & w_p[c_base] & w_c[c_base]);
            assign w_gg[gi] = w_g[c_base+3]
                            | (w_p[c_base+3] & w_g[c_base+2])
                            | (w_p[c_base+3] & w_p[c_base+2] & w_g[c_base+1])
                            | (w_p[c_base+3] & w_p[c_base+2] & w_p[c_base+1] & w_g[c_base]);
            assign w_gp[gi] = &w_p[c_base+3:c_base];
            assign w_c[c_base+4] = w_gg[gi] | (w_gp[gi] & w_c[c_base]);
        end
    endgenerate

    assign o_sum   = w_p ^ w_c[19:0];
    assign o_c_out = w_c[20];

endmodule
`default_nettype wire

// File: rtl/chunked_add_sub_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : chunked_add_sub_sequencer
// Brief    : Multi-cycle 64-bit add/subtract. One 20-bit CLA slice is reused
//            over four chunks (20/20/20/4) with a registered chained carry.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_add_sub_sequencer
    import chunked_add_sub_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    state_t           r_state;
    state_t           w_state_next;
    idx_t             r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_eff;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;

    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_sum;
    logic             w_c_out;

    carry_look_ahead_adder_20 u_cla (
        .i_a     (w_a_chunk),
        .i_b     (w_b_chunk),
        .i_c_in  (r_carry),
        .o_sum   (w_sum),
        .o_c_out (w_c_out)
    );

    // Select the operand chunk for the current index; last chunk is zero-extended.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        case (r_idx)
            2'd0: begin
                w_a_chunk = r_a[0*CHUNK +: CHUNK];
                w_b_chunk = r_b_eff[0*CHUNK +: CHUNK];
            end
            2'd1: begin
                w_a_chunk = r_a[1*CHUNK +: CHUNK];
                w_b_chunk = r_b_eff[1*CHUNK +: CHUNK];
            end
            2'd2: begin
                w_a_chunk = r_a[2*CHUNK +: CHUNK];
                w_b_chunk = r_b_eff[2*CHUNK +: CHUNK];
            end
            default: begin
                w_a_chunk = {{(CHUNK-LAST_BITS){1'b0}}, r_a[WIDTH-1 -: LAST_BITS]};
                w_b_chunk = {{(CHUNK-LAST_BITS){1'b0}}, r_b_eff[WIDTH-1 -: LAST_BITS]};
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_idx == idx_t'(NUM_CHUNKS - 1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, per-chunk result write-back and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_a         <= '0;
            r_b_eff     <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b_eff <= op_sub ? ~b : b;
                        r_carry <= op_sub;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_idx   <= r_idx + 2'd1;
                    r_carry <= w_c_out;
                    case (r_idx)
                        2'd0: r_result[0*CHUNK +: CHUNK] <= w_sum;
                        2'd1: r_result[1*CHUNK +: CHUNK] <= w_sum;
                        2'd2: r_result[2*CHUNK +: CHUNK] <= w_sum;
                        default: begin
                            // Final 4-bit chunk: carry comes from sum bit 4, not the slice carry.
                            r_result[WIDTH-1 -: LAST_BITS] <= w_sum[LAST_BITS-1:0];
                            r_carry_out <= w_sum[LAST_BITS];
                            r_overflow  <= (r_a[WIDTH-1] == r_b_eff[WIDTH-1])
                                        && (w_sum[LAST_BITS-1] != r_a[WIDTH-1]);
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_chunked_add_sub_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_add_sub_sequencer
// Brief    : Scoreboard bench for chunked_add_sub_sequencer with directed
//            vectors, latency, hold and mid-operation reset checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_add_sub_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        carry_out;
    logic        overflow;

    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   n_pass;
    int   n_total;

    chunked_add_sub_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: compare each retiring result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.r);
                chk("carry_out", {63'd0, carry_out}, {63'd0, e.c});
                chk("overflow", {63'd0, overflow}, {63'd0, e.v});
            end
        end
    end

    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic ts,
                          input logic [63:0] er, input logic ec, input logic ev, input int hold);
        int lat;
        exp_t e;
        @(negedge clk);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        a        = ta;
        b        = tb_v;
        op_sub   = ts;
        in_valid = 1'b1;
        e.r = er; e.c = ec; e.v = ev;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = '1;
        b        = '1;
        op_sub   = ~ts;
        chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_result", result, er);
            chk("hold_ovf", {63'd0, overflow}, {63'd0, ev});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("retire_valid", {63'd0, out_valid}, 64'd0);
        chk("retire_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_carry", {63'd0, carry_out}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        run_op(64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0, 0);
        run_op(64'h0000_0000_000F_FFFF, 64'd1, 1'b0, 64'h0000_0000_0010_0000, 1'b0, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 0);
        run_op(64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 3);
        run_op(64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
        run_op(64'h0000_0FFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_1000_0000_0000, 1'b0, 1'b0, 0);

        // Abort an operation during its second RUN cycle; nothing is pushed for it.
        @(negedge clk);
        a = 64'd10; b = 64'd20; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_carry", {63'd0, carry_out}, 64'd0);
        chk("abort_ovf", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort_valid_after", {63'd0, out_valid}, 64'd0);

        run_op(64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
